// File: rtl/stream_fifo_quota_arb_pkg.sv
// Shared state encoding and sizing helper for the quota-limited stream FIFO arbiter.
package stream_fifo_quota_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_rr_sel.sv
// Round-robin first-set finder: picks the first eligible source at or after rr_ptr, wrapping.
module stream_fifo_rr_sel
  import stream_fifo_quota_arb_pkg::*;
#(
  parameter int unsigned NumSrc = 4,
  parameter int unsigned IdxW   = idx_width(NumSrc)
) (
  input  logic [NumSrc-1:0] eligible,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   sel,
  output logic              any
);

  logic [IdxW-1:0] cand;

  // Scan from the farthest offset down so the closest eligible source to rr_ptr wins.
  always_comb begin
    sel  = rr_ptr;
    any  = 1'b0;
    cand = '0;
    for (int k = int'(NumSrc) - 1; k >= 0; k--) begin
      cand = IdxW'((int'(rr_ptr) + k) % int'(NumSrc));
      if (eligible[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_fifo_quota_arbiter.sv
// Round-robin, per-source quota-limited arbiter for the push side of a shared stream FIFO.
// Optional per-source performance counters: define STREAM_FIFO_QUOTA_ARB_PERF_EN.
module stream_fifo_quota_arbiter
  import stream_fifo_quota_arb_pkg::*;
#(
  parameter int unsigned NumSrc = 4,
  parameter int unsigned Quota  = 4,
  parameter type         type_t = logic,
  localparam int unsigned IdxW  = idx_width(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  type_t [NumSrc-1:0]      req_data_i,
  input  logic  [NumSrc-1:0]      req_valid_i,
  output logic  [NumSrc-1:0]      req_ready_o,
  output type_t                   data_o,
  output logic  [IdxW-1:0]        idx_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  input  logic                    pop_i,
  input  logic  [IdxW-1:0]        pop_idx_i,
  output logic                    busy_o
`ifdef STREAM_FIFO_QUOTA_ARB_PERF_EN
  ,
  output logic  [NumSrc-1:0][31:0] grant_cnt_o,
  output logic  [NumSrc-1:0]       quota_stall_o
`endif
);

  localparam int unsigned     CntW    = $clog2(Quota + 1);
  localparam logic [CntW-1:0] QuotaC  = CntW'(Quota);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSrc - 1);

  arb_state_e                  state_q, state_d;
  logic [IdxW-1:0]             sel_q, sel_d;
  logic [IdxW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]             arb_sel, sel;
  logic                        arb_any;
  logic [NumSrc-1:0][CntW-1:0] cnt_q;
  logic [NumSrc-1:0]           eligible, cnt_nz, inc, dec;
  logic                        blocked, push;

  assign blocked = rst_i | flush_i;

  always_comb begin
    eligible = '0;
    cnt_nz   = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < QuotaC);
      cnt_nz[i]   = (cnt_q[i] != '0);
    end
  end

  stream_fifo_rr_sel #(
    .NumSrc (NumSrc),
    .IdxW   (IdxW)
  ) u_rr_sel (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .sel      (arb_sel),
    .any      (arb_any)
  );

  // A held grant ignores quota and competing requests until its handshake completes.
  assign sel = (state_q == HOLD) ? sel_q : arb_sel;

  always_comb begin
    valid_o     = 1'b0;
    req_ready_o = '0;
    data_o      = '0;
    idx_o       = '0;
    if (!blocked) begin
      valid_o          = (state_q == HOLD) || arb_any;
      data_o           = req_data_i[sel];
      idx_o            = sel;
      req_ready_o[sel] = ready_i & valid_o;
    end
  end

  assign push   = valid_o & ready_i;
  assign busy_o = (|cnt_nz) & ~blocked;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      inc[i] = push && (sel == IdxW'(i));
      dec[i] = pop_i && (pop_idx_i == IdxW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      state_d  = ARB;
      sel_d    = '0;
      rr_ptr_d = '0;
    end else begin
      if (push) begin
        rr_ptr_d = (sel == LastIdx) ? '0 : sel + 1'b1;
      end
      case (state_q)
        ARB: begin
          if (valid_o && !ready_i) begin
            state_d = HOLD;
            sel_d   = sel;
          end
        end
        HOLD: begin
          if (ready_i) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A same-cycle push and pop to one source cancel; a pop at zero saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NumSrc); i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !inc[i] && cnt_nz[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

`ifdef STREAM_FIFO_QUOTA_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      grant_cnt_o <= '0;
    end else begin
      for (int i = 0; i < int'(NumSrc); i++) begin
        if (inc[i]) begin
          grant_cnt_o[i] <= grant_cnt_o[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    quota_stall_o = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      quota_stall_o[i] = req_valid_i[i] && (cnt_q[i] == QuotaC);
    end
  end
`endif

  pop_idx_in_range: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    pop_i |-> (|dec));

  pop_not_empty: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    pop_i |-> (|(dec & cnt_nz)));

  held_req_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (valid_o && !ready_i) |=> (req_valid_i[sel_q] && (req_data_i[sel_q] == $past(req_data_i[sel]))));

endmodule

// File: tb/tb_stream_fifo_quota_arbiter.sv
// Scoreboard bench for stream_fifo_quota_arbiter (NumSrc=4, Quota=2, 8-bit payload).
module tb_stream_fifo_quota_arbiter;

  localparam int NumSrc = 4;
  localparam int Quota  = 2;
  localparam int IdxW   = 2;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [IdxW-1:0] idx;
    byte_t           data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst, flush, ready, pop;
  logic [NumSrc-1:0]        req_valid, req_ready;
  byte_t [NumSrc-1:0]       req_data;
  byte_t                    data;
  logic [IdxW-1:0]          idx, pop_idx;
  logic                     valid, busy;
`ifdef STREAM_FIFO_QUOTA_ARB_PERF_EN
  logic [NumSrc-1:0][31:0]  grant_cnt;
  logic [NumSrc-1:0]        quota_stall;
`endif

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stream_fifo_quota_arbiter #(
    .NumSrc (NumSrc),
    .Quota  (Quota),
    .type_t (byte_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req_data_i    (req_data),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .data_o        (data),
    .idx_o         (idx),
    .valid_o       (valid),
    .ready_i       (ready),
    .pop_i         (pop),
    .pop_idx_i     (pop_idx),
    .busy_o        (busy)
`ifdef STREAM_FIFO_QUOTA_ARB_PERF_EN
    ,
    .grant_cnt_o   (grant_cnt),
    .quota_stall_o (quota_stall)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic r, input logic p,
                               input logic [1:0] pi, input logic f);
    req_valid = v;
    ready     = r;
    pop       = p;
    pop_idx   = pi;
    flush     = f;
  endtask

  task automatic expPush(input int s);
    exp_t e;
    e.idx  = IdxW'(s);
    e.data = byte_t'(8'h11 * (s + 1));
    exp_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Leaves the DUT holding a grant on src1 with cnt={2,1,0,0} and rr_ptr=2.
  task automatic setupHold();
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(0);
    nextCycle();
    expPush(0);
    nextCycle();
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(1);
    nextCycle();
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("hold_pre_idx", 32'(idx), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    checkOutput("hold_idx", 32'(idx), 32'd1);
    nextCycle();
  endtask

  // Scoreboard monitor: every push handshake must match the oldest expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL push_unexpected: got idx %0d data %0h, expected no push", idx, data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("push_idx", 32'(idx), 32'(e.idx));
        checkOutput("push_data", 32'(data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_idx", 32'(idx), 32'd0);
    checkOutput("rst_data", 32'(data), 32'd0);
    resetDut();

    // Test 1: all sources request, quota of 2 each fills in round-robin order.
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 8; k++) expPush(k % NumSrc);
    repeat (8) nextCycle();
    @(negedge clk);
    checkOutput("t1_quota_valid", 32'(valid), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(4'b1111, 1'b0, 1'b1, 2'd2, 1'b0);
    nextCycle();
    applyStimulus(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t1_pop_frees_valid", 32'(valid), 32'd1);
    checkOutput("t1_pop_frees_idx", 32'(idx), 32'd2);
    resetDut();

    // Test 2: grant lock on src2 while src0 arrives, then pointer moves past src2.
    applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_c0_idx", 32'(idx), 32'd2);
    checkOutput("t2_c0_valid", 32'(valid), 32'd1);
    checkOutput("t2_c0_ready", 32'(req_ready), 32'd0);
    nextCycle();
    applyStimulus(4'b0101, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_c1_idx", 32'(idx), 32'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_c2_idx", 32'(idx), 32'd2);
    nextCycle();
    applyStimulus(4'b0101, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(2);
    @(negedge clk);
    checkOutput("t2_hs_ready", 32'(req_ready), 32'b0100);
    nextCycle();
    expPush(0);
    @(negedge clk);
    checkOutput("t2_next_idx", 32'(idx), 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    resetDut();

    // Test 3: simultaneous push and pop on src1 leaves its count unchanged.
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(1);
    nextCycle();
    applyStimulus(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    expPush(1);
    @(negedge clk);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    nextCycle();
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(1);
    @(negedge clk);
    checkOutput("t3_still_eligible", 32'(valid), 32'd1);
    nextCycle();
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t3_quota_reached", 32'(valid), 32'd0);
    resetDut();

    // Test 4: pointer wrap between src3 and src0 after priming rr_ptr to 3.
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(2);
    nextCycle();
    applyStimulus(4'b1001, 1'b1, 1'b0, 2'd0, 1'b0);
    expPush(3);
    expPush(0);
    expPush(3);
    expPush(0);
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("t4_quota_valid", 32'(valid), 32'd0);
    resetDut();

    // Test 5: flush during a held grant.
    setupHold();
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_flush_valid", 32'(valid), 32'd0);
    checkOutput("t5_flush_ready", 32'(req_ready), 32'd0);
    checkOutput("t5_flush_idx", 32'(idx), 32'd0);
    checkOutput("t5_flush_data", 32'(data), 32'd0);
    nextCycle();
    applyStimulus(4'b1011, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t5_after_busy", 32'(busy), 32'd0);
    checkOutput("t5_after_valid", 32'(valid), 32'd1);
    checkOutput("t5_after_idx", 32'(idx), 32'd0);
    resetDut();

    // Test 6: reset during a held grant.
    setupHold();
    rst = 1'b1;
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t6_rst_valid", 32'(valid), 32'd0);
    checkOutput("t6_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(4'b1011, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t6_after_busy", 32'(busy), 32'd0);
    checkOutput("t6_after_valid", 32'(valid), 32'd1);
    checkOutput("t6_after_idx", 32'(idx), 32'd0);
`ifdef STREAM_FIFO_QUOTA_ARB_PERF_EN
    for (int i = 0; i < NumSrc; i++) begin
      checkOutput("t6_grant_cnt", grant_cnt[i], 32'd0);
    end
`endif
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    nextCycle();

    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
